timer_counter: RTL and testbench
================================

# timer_counter

Programmable 32-bit down-counter, memory-mapped on the CPU's peripheral bus, that raises a level or pulse interrupt request. It is the source end of the hardware-interrupt path: its `irq` output drives `HWint[2]` of the coprocessor-0 block, which masks, latches and vectors it. Software configures it through three word registers with ordinary store/load instructions.

## Interface
Parameters:
- `RESET_PRESET`, default 32'h0000_0000: PRESET value after reset.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `addr` in 2: word select, bus address bits [3:2]. 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- `we` in 1: write strobe, sampled at the rising edge.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read of the selected register.
- `irq` out 1: interrupt request to the CP0 `HWint[2]` input.

## Operation
- CTRL fields:
  - [0] EN: enable.
  - [2:1] MODE: 0 one-shot; 1 auto-reload; 2 and 3 behave as 0.
  - [3] IM: interrupt mask, 1 = irq allowed.
  - CTRL reads {28'b0, IM, MODE, EN}.
- PRESET: R/W, 32 bits.
- COUNT: read-only; writes ignored.
- Reserved address 3 reads 0; writes to it are ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - EN=0: go to IDLE; COUNT holds its value.
    - COUNT==0: go to INT.
    - Otherwise COUNT <= COUNT-1.
  - INT, MODE 0: irq_flag <= 1; EN <= 0; go to IDLE.
  - INT, MODE 1: go to LOAD.
- irq:
  - MODE 0: `irq = irq_flag & IM`. Level output, held until cleared.
  - MODE 1: `irq = IM & (state==INT)`. One-cycle pulse per period.
- irq_flag clears on any write to CTRL or PRESET.
- Arithmetic is unsigned 32-bit. COUNT never wraps, because decrement only happens when COUNT != 0.

## Timing
- Reset values:
  - State IDLE.
  - CTRL = 0.
  - PRESET = `RESET_PRESET`.
  - COUNT = 0.
  - irq_flag = 0.
  - `irq` = 0.
- Register writes take effect at the edge where `we` is sampled. `rdata` reflects the new value in the following cycle.
- One-shot latency: with CTRL written {IM=1,MODE=0,EN=1} at edge E, `irq` rises after edge E+PRESET+4:
  - LOAD at E+1.
  - COUNT=PRESET at E+2.
  - COUNT reaches 0 at E+PRESET+2.
  - INT at E+PRESET+3.
  - flag set at E+PRESET+4.
- Auto-reload period is PRESET+3 cycles. The `irq` pulse is 1 cycle wide.
- Simultaneous events:
  - CTRL write in the same cycle as INT: the written EN wins over the hardware clear of EN, and the flag set wins over the write-clear, so no event is lost.
  - PRESET write mid-count: does not affect the current run; the new value is used at the next LOAD.
  - PRESET=0: LOAD, then CNT, then INT with no decrement.
  - IM=0: the counter runs and irq_flag still sets, but `irq` stays 0. Setting IM later (without EN) exposes the pending flag? No: a CTRL write clears the flag, so a masked one-shot event is discarded.
- Reset asserted mid-count: outputs go to reset values asynchronously, and `irq` drops in the same cycle.

## Structure
- Shared package `timer_pkg`:
  - State encoding enum.
  - Register word indices (CTRL=0, PRESET=1, COUNT=2).
  - MODE constants (ONESHOT=0, RELOAD=1).
  - CTRL bit positions.
- Single module, no sub-module: the register file and FSM are small and tightly coupled.

## Test plan
- Reset mid-count, with PRESET=100 running: assert reset → COUNT=0, CTRL=0, `irq`=0 in the same cycle; FSM IDLE after release.
- One-shot: PRESET=3, write CTRL=4'b1001 at edge E → `irq` 0 through edge E+6 and 1 from edge E+7; CTRL reads 4'b1000 (EN cleared); `irq` stays high until a write to CTRL=0, then 0 the next cycle.
- Auto-reload: PRESET=2, CTRL=4'b1011 → `irq` 1-cycle pulses every 5 cycles across at least 4 periods; COUNT sequence 2,1,0,0,(INT),2,...
- Mask: PRESET=1, CTRL=4'b0001 → `irq` never asserts; CTRL EN reads 0 after 5 cycles; COUNT reads 0.
- Disable mid-count: PRESET=10, enable, then write CTRL=4'b1000 when COUNT=6 → COUNT holds 6, no `irq`. Re-enable → COUNT reloads to 10.
- Corner cases:
  - PRESET=0 one-shot → `irq` after edge E+4.
  - Write to COUNT during run is ignored.
  - Address 3 reads 0.
  - PRESET write at the INT cycle sets no-loss flag, so `irq`=1 afterward.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable down-counter: FSM encoding,
// register word indices, MODE values and CTRL bit positions.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM       = 3;

  function automatic logic [31:0] ctrl_word(input logic im, input logic [1:0] mode,
                                            input logic en);
    return {28'd0, im, mode, en};
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counter with one-shot / auto-reload modes that
// drives the CP0 HWint[2] interrupt request.
module timer_counter
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t      state;
  state_t      state_next;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        do_load;
  logic        do_dec;
  logic        do_fire;
  logic        wr_ctrl;
  logic        wr_preset;

  assign wr_ctrl   = we && (addr == REG_CTRL);
  assign wr_preset = we && (addr == REG_PRESET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_dec     = 1'b0;
    do_fire    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_next = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        do_load    = 1'b1;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_next = ST_IDLE;
        end else if (count == 32'd0) begin
          state_next = ST_INT;
        end else begin
          do_dec     = 1'b1;
          state_next = ST_CNT;
        end
      end
      ST_INT: begin
        // MODE values 2 and 3 fall through to one-shot behaviour.
        if (mode == MODE_RELOAD) begin
          state_next = ST_LOAD;
        end else begin
          do_fire    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A CTRL write in the firing cycle keeps the written EN, and the flag set
  // beats the write-clear, so a coincident event is never dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b0;
      mode     <= MODE_ONESHOT;
      im       <= 1'b0;
      preset   <= RESET_PRESET;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en   <= wdata[CTRL_EN];
        mode <= wdata[CTRL_MODE_LSB +: 2];
        im   <= wdata[CTRL_IM];
      end else if (do_fire) begin
        en <= 1'b0;
      end

      if (wr_preset) begin
        preset <= wdata;
      end

      if (do_load) begin
        count <= preset;
      end else if (do_dec) begin
        count <= count - 32'd1;
      end

      if (do_fire) begin
        irq_flag <= 1'b1;
      end else if (wr_ctrl || wr_preset) begin
        irq_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      REG_CTRL:   rdata = ctrl_word(im, mode, en);
      REG_PRESET: rdata = preset;
      REG_COUNT:  rdata = count;
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = (mode == MODE_RELOAD) ? (im & (state == ST_INT)) : (irq_flag & im);

endmodule

// File: tb/tb_timer_counter.sv
// Directed + randomized bench for timer_counter against a period-position
// reference model of the counter.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  timer_counter #(.RESET_PRESET(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model: a run is a period of rp+3 positions.
  // pos 0 = loading, pos 1..rp+1 = counting (count = rp-(pos-1)), pos rp+2 = event.
  bit          m_en, m_im, m_flag, m_active;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count, m_rp;
  int          m_pos;

  task automatic model_reset();
    m_en = 1'b0; m_im = 1'b0; m_flag = 1'b0; m_active = 1'b0;
    m_mode = 2'd0; m_preset = 32'd0; m_count = 32'd0; m_rp = 32'd0; m_pos = 0;
  endtask

  function automatic bit m_at_event();
    return m_active && (m_pos == int'(m_rp) + 2);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    if (m_mode == 2'd1) return m_im && m_at_event();
    return m_flag && m_im;
  endfunction

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
    bit         en0   = m_en;
    logic [1:0] mode0 = m_mode;
    bit         fire  = 1'b0;
    if (!m_active) begin
      if (en0) begin m_active = 1'b1; m_pos = 0; end
    end else if (m_pos == 0) begin
      m_rp = m_preset; m_count = m_preset; m_pos = 1;
    end else if (!m_at_event()) begin
      if (!en0) m_active = 1'b0;
      else begin
        m_pos++;
        if (m_pos <= int'(m_rp) + 1) m_count = m_rp - 32'(m_pos - 1);
      end
    end else begin
      if (mode0 == 2'd1) m_pos = 0;
      else begin m_active = 1'b0; fire = 1'b1; end
    end
    if (w && a == 2'd0) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3];
    end else if (fire) m_en = 1'b0;
    if (w && a == 2'd1) m_preset = d;
    if (fire) m_flag = 1'b1;
    else if (w && (a == 2'd0 || a == 2'd1)) m_flag = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle, compare outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; addr = a; wdata = d;
    #1;
    check("irq", {31'd0, irq}, {31'd0, m_irq()});
    check("rdata", rdata, m_rdata(a));
    @(posedge clk);
    model_edge(w, a, d);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // reset state
    step(1'b0, 2'd0, 32'd0);
    step(1'b0, 2'd1, 32'd0);
    step(1'b0, 2'd2, 32'd0);

    // one-shot, PRESET=3: irq from edge E+7, EN cleared
    step(1'b1, 2'd1, 32'd3);
    step(1'b1, 2'd0, 32'd9);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 2'd0, 32'd0);
      check("oneshot_irq", {31'd0, irq}, {31'd0, (k >= 8)});
    end
    check("oneshot_ctrl", rdata, 32'h8);
    step(1'b1, 2'd0, 32'd0);
    step(1'b0, 2'd0, 32'd0);
    check("oneshot_clear", {31'd0, irq}, 32'd0);

    // auto-reload, PRESET=2: pulse every 5 cycles
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'd11);
    for (int k = 1; k <= 22; k++) begin
      step(1'b0, 2'd2, 32'd0);
      check("reload_irq", {31'd0, irq}, {31'd0, (k >= 6 && (k - 6) % 5 == 0)});
    end
    step(1'b1, 2'd0, 32'd0);

    // masked one-shot, PRESET=1
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'd1);
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 2'd0, 32'd0);
      check("mask_irq", {31'd0, irq}, 32'd0);
    end
    check("mask_ctrl", rdata, 32'd0);
    step(1'b0, 2'd2, 32'd0);
    check("mask_count", rdata, 32'd0);

    // disable mid-count, PRESET=10
    step(1'b1, 2'd1, 32'd10);
    step(1'b1, 2'd0, 32'd9);
    for (int k = 1; k <= 5; k++) step(1'b0, 2'd2, 32'd0);
    step(1'b1, 2'd0, 32'd8);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 2'd2, 32'd0);
      check("disable_hold", rdata, 32'd6);
    end
    step(1'b1, 2'd0, 32'd9);
    step(1'b0, 2'd2, 32'd0);
    step(1'b0, 2'd2, 32'd0);
    step(1'b0, 2'd2, 32'd0);
    check("reenable_reload", rdata, 32'd10);
    step(1'b1, 2'd0, 32'd0);

    // PRESET=0 one-shot: irq from edge E+4
    step(1'b1, 2'd1, 32'd0);
    step(1'b1, 2'd0, 32'd9);
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 2'd0, 32'd0);
      check("preset0_irq", {31'd0, irq}, {31'd0, (k >= 5)});
    end
    step(1'b1, 2'd0, 32'd0);

    // COUNT write ignored, address 3 reads 0
    step(1'b1, 2'd1, 32'd5);
    step(1'b1, 2'd0, 32'd3);
    step(1'b0, 2'd2, 32'd0);
    step(1'b0, 2'd2, 32'd0);
    step(1'b1, 2'd2, 32'hDEAD_BEEF);
    step(1'b0, 2'd2, 32'd0);
    check("count_write_ignored", rdata, 32'd4);
    step(1'b1, 2'd3, 32'hFFFF_FFFF);
    step(1'b0, 2'd3, 32'd0);
    check("reserved_zero", rdata, 32'd0);
    step(1'b1, 2'd0, 32'd0);

    // PRESET write in the INT cycle: flag still sets
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'd9);
    for (int k = 1; k <= 5; k++) step(1'b0, 2'd0, 32'd0);
    step(1'b1, 2'd1, 32'd7);
    step(1'b0, 2'd0, 32'd0);
    check("int_write_noloss", {31'd0, irq}, 32'd1);

    // reset mid-count with PRESET=100 running
    step(1'b1, 2'd1, 32'd100);
    step(1'b1, 2'd0, 32'd9);
    for (int k = 1; k <= 10; k++) step(1'b0, 2'd2, 32'd0);
    @(negedge clk);
    we = 1'b0; addr = 2'd2;
    #2 reset = 1'b1;
    #1;
    check("reset_count", rdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    addr = 2'd0;
    #1;
    check("reset_ctrl", rdata, 32'd0);
    model_reset();
    @(negedge clk) reset = 1'b0;
    for (int k = 1; k <= 3; k++) step(1'b0, 2'd2, 32'd0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [1:0]  a;
      logic        w;
      logic [31:0] d;
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 5) == 0);
      if (a == 2'd1) d = 32'($urandom_range(0, 6));
      else if (a == 2'd0) d = 32'($urandom_range(0, 15));
      else d = $urandom;
      step(w, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
